// File: rtl/filter_window_controller.sv
// Frame sequencer for the image filter window chain: tracks raster position,
// gates pixel acceptance against the single-entry window slot, and flags full windows.
module filter_window_controller #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int COL_BITS   = 6,
   parameter int ROW_BITS   = 6,
   parameter int KERNEL     = 3
) (
   input  logic                clk,
   input  logic                async_reset_n,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                shift_en,
   output logic [COL_BITS-1:0] lb_addr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ROW_BITS-1:0] out_row,
   output logic [COL_BITS-1:0] out_col,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(IMG_WIDTH - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(IMG_HEIGHT - 1);
   localparam logic [COL_BITS-1:0] COL_FIRST = COL_BITS'(KERNEL - 1);
   localparam logic [ROW_BITS-1:0] ROW_FIRST = ROW_BITS'(KERNEL - 1);
   localparam logic [COL_BITS-1:0] COL_HALF  = COL_BITS'(KERNEL / 2);
   localparam logic [ROW_BITS-1:0] ROW_HALF  = ROW_BITS'(KERNEL / 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [COL_BITS-1:0] r_col;
   logic [ROW_BITS-1:0] r_row;
   logic                r_out_valid;
   logic [ROW_BITS-1:0] r_out_row;
   logic [COL_BITS-1:0] r_out_col;

   logic w_in_ready;
   logic w_shift;
   logic w_last_px;
   logic w_win_px;
   logic w_start;

   // Accept only while the window slot is empty or being emptied this cycle,
   // so at most one unconsumed window ever exists.
   assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
   assign w_shift    = in_valid && w_in_ready;
   assign w_last_px  = (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_win_px   = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST);
   assign w_start    = (r_state == S_IDLE) && start;

   always_comb begin
      // NOTE: default first so every path assigns the next state and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_shift && w_last_px) w_state_nxt = S_DRAIN;
         S_DRAIN: if (!r_out_valid || out_ready) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_shift) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            // Row holds on the final pixel; start clears it for the next frame.
            if (!w_last_px) r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // A window-completing accept overrides a same-cycle consume, giving back-to-back windows.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         r_out_valid <= 1'b0;
         r_out_row   <= '0;
         r_out_col   <= '0;
      end else if (w_shift && w_win_px) begin
         r_out_valid <= 1'b1;
         r_out_row   <= r_row - ROW_HALF;
         r_out_col   <= r_col - COL_HALF;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready   = w_in_ready;
   assign shift_en   = w_shift;
   assign lb_addr    = r_col;
   assign out_valid  = r_out_valid;
   assign out_row    = r_out_row;
   assign out_col    = r_out_col;
   assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign frame_done = (r_state == S_DONE);

endmodule

// File: tb/tb_filter_window_controller.sv
// Randomized bench for filter_window_controller: a behavioural frame model plus
// a scoreboard of expected window centres checks every cycle.
module tb_filter_window_controller;

   localparam int W    = 8;
   localparam int H    = 5;
   localparam int K    = 3;
   localparam int CB   = 3;
   localparam int RB   = 3;
   localparam int NWIN = (W - K + 1) * (H - K + 1);

   logic          clk = 1'b0;
   logic          async_reset_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          shift_en;
   logic [CB-1:0] lb_addr;
   logic          out_valid;
   logic [RB-1:0] out_row;
   logic [CB-1:0] out_col;
   logic          busy;
   logic          frame_done;

   filter_window_controller #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .COL_BITS  (CB),
      .ROW_BITS  (RB),
      .KERNEL    (K)
   ) dut (
      .clk          (clk),
      .async_reset_n(async_reset_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .shift_en     (shift_en),
      .lb_addr      (lb_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_row      (out_row),
      .out_col      (out_col),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural frame model: phase flags, accept count and the pending window.
   bit m_run;
   bit m_drain;
   bit m_done;
   bit m_ov;
   int m_acc;
   int m_orow;
   int m_ocol;
   int q_row[$];
   int q_col[$];
   int consumed;
   int shifts;
   int fd_seen;

   task automatic model_reset();
      m_run    = 1'b0;
      m_drain  = 1'b0;
      m_done   = 1'b0;
      m_ov     = 1'b0;
      m_acc    = 0;
      m_orow   = 0;
      m_ocol   = 0;
      consumed = 0;
      shifts   = 0;
      q_row.delete();
      q_col.delete();
   endtask

   task automatic fill_scoreboard();
      q_row.delete();
      q_col.delete();
      for (int r = K - 1; r < H; r++)
         for (int c = K - 1; c < W; c++) begin
            q_row.push_back(r - K / 2);
            q_col.push_back(c - K / 2);
         end
   endtask

   task automatic reset_checks();
      check("rst_in_ready",   32'(in_ready),   0);
      check("rst_shift_en",   32'(shift_en),   0);
      check("rst_out_valid",  32'(out_valid),  0);
      check("rst_out_row",    32'(out_row),    0);
      check("rst_out_col",    32'(out_col),    0);
      check("rst_busy",       32'(busy),       0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_lb_addr",    32'(lb_addr),    0);
   endtask

   // One clock cycle: drive inputs at the falling edge, check, then advance the model.
   task automatic step(input bit s, input bit iv, input bit ordy);
      bit exp_rdy;
      bit was_ov;
      bit was_drain;
      bit was_done;
      bit idle;
      int r;
      int c;
      @(negedge clk);
      start     = s;
      in_valid  = iv;
      out_ready = ordy;
      #1;
      exp_rdy = m_run && (!m_ov || ordy);
      check("in_ready",   32'(in_ready),   32'(exp_rdy));
      check("shift_en",   32'(shift_en),   32'(exp_rdy && iv));
      check("busy",       32'(busy),       32'(m_run || m_drain));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("out_valid",  32'(out_valid),  32'(m_ov));
      if (m_ov) begin
         check("out_row", 32'(out_row), m_orow);
         check("out_col", 32'(out_col), m_ocol);
      end
      if (m_run) check("lb_addr", 32'(lb_addr), m_acc % W);
      if (m_ov && ordy) begin
         check("sb_nonempty", 32'(q_row.size() > 0), 1);
         if (q_row.size() > 0) begin
            check("sb_row", 32'(out_row), q_row.pop_front());
            check("sb_col", 32'(out_col), q_col.pop_front());
         end
         consumed++;
      end
      if (m_done) fd_seen++;

      was_ov    = m_ov;
      was_drain = m_drain;
      was_done  = m_done;
      idle      = !m_run && !m_drain && !m_done;
      if (exp_rdy && iv) begin
         r = m_acc / W;
         c = m_acc % W;
         shifts++;
         m_acc++;
         if (r >= K - 1 && c >= K - 1) begin
            m_ov   = 1'b1;
            m_orow = r - K / 2;
            m_ocol = c - K / 2;
         end else if (ordy) begin
            m_ov = 1'b0;
         end
         if (m_acc == W * H) begin
            m_run   = 1'b0;
            m_drain = 1'b1;
         end
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      if (was_drain && (!was_ov || ordy)) begin
         m_drain = 1'b0;
         m_done  = 1'b1;
      end
      if (was_done) m_done = 1'b0;
      if (idle && s) begin
         m_run    = 1'b1;
         m_acc    = 0;
         consumed = 0;
         shifts   = 0;
         fill_scoreboard();
      end
   endtask

   // mode 0: streaming; mode 1: random gaps/stalls/stray starts; mode 2: 5-cycle stall after first window.
   task automatic run_frame(input int mode);
      int  fd_before;
      int  bp;
      bit  seen_first;
      bit  s;
      bit  iv;
      bit  ordy;
      fd_before  = fd_seen;
      bp         = 0;
      seen_first = 1'b0;
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3000 && fd_seen == fd_before; i++) begin
         s    = 1'b0;
         iv   = 1'b1;
         ordy = 1'b1;
         if (mode == 1) begin
            s    = ($urandom_range(0, 7) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 3) != 0);
         end else if (mode == 2) begin
            ordy = (bp == 0);
         end
         step(s, iv, ordy);
         if (mode == 2) begin
            if (!seen_first && m_ov) begin
               seen_first = 1'b1;
               bp         = 5;
            end else if (bp > 0) begin
               bp--;
            end
         end
      end
      check("frame_finished", fd_seen, fd_before + 1);
      check("shift_count",    shifts,  W * H);
      check("window_count",   consumed, NWIN);
      check("sb_drained",     q_row.size(), 0);
   endtask

   initial begin
      model_reset();
      fd_seen = 0;
      in_valid = 1'b1;
      #12;
      reset_checks();
      @(negedge clk);
      in_valid = 1'b0;
      async_reset_n = 1'b1;

      repeat (4) step(1'b0, 1'b1, 1'b1);

      run_frame(0);
      run_frame(2);
      repeat (3) run_frame(1);

      // Abort a frame mid-run with an asynchronous reset between clock edges.
      step(1'b1, 1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #3;
      async_reset_n = 1'b0;
      #1;
      reset_checks();
      model_reset();
      @(negedge clk);
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      async_reset_n = 1'b1;
      repeat (3) step(1'b0, 1'b1, 1'b1);

      run_frame(0);
      run_frame(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
